// File: rtl/serial_adder_scheduler.sv
// Round-robin front end for a single shared bit-serial adder: arbitrates N
// requesters, sequences the core through load/run, and returns sum/carry.
module serial_adder_scheduler #(
  parameter int unsigned N   = 4,
  parameter int unsigned W   = 8,
  parameter int unsigned LAT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   sum,
  output logic           cout,
  output logic           add_rst,
  output logic           add_mode,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  input  logic [W-1:0]   add_ans,
  input  logic           add_carry
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            add_rst_q, add_rst_d;
  logic            add_mode_q, add_mode_d;
  logic [W-1:0]    add_a_q, add_a_d;
  logic [W-1:0]    add_b_q, add_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;

  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   scan_idx;
  logic            found;

  // Scan starting at the rotation pointer; first hit wins.
  always_comb begin
    pick_idx = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = PW'((32'(ptr_q) + k) % N);
      if (!found && req[scan_idx]) begin
        found    = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sum_d      = sum_q;
    cout_d     = cout_q;
    add_rst_d  = 1'b0;
    add_mode_d = add_mode_q;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    unique case (state_q)
      IDLE: begin
        add_mode_d = 1'b0;
        if (found) begin
          state_d           = LOAD;
          win_d             = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          add_a_d           = a_in[pick_idx*W +: W];
          add_b_d           = b_in[pick_idx*W +: W];
          add_rst_d         = 1'b1;
          add_mode_d        = 1'b1;
          cnt_d             = '0;
          busy_d            = 1'b1;
        end
      end
      LOAD: begin
        state_d    = RUN;
        add_mode_d = 1'b1;
      end
      RUN: begin
        if (cnt_q == CW'(LAT - 1)) begin
          sum_d      = add_ans;
          cout_d     = add_carry;
          state_d    = DONE;
          done_d     = 1'b1;
          add_mode_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      add_rst_q  <= 1'b1;
      add_mode_q <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      cnt_q      <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      add_rst_q  <= add_rst_d;
      add_mode_q <= add_mode_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign add_rst  = add_rst_q;
  assign add_mode = add_mode_q;
  assign add_a    = add_a_q;
  assign add_b    = add_b_q;

endmodule

// File: tb/tb_serial_adder_scheduler.sv
// Bench for serial_adder_scheduler: behavioural adder stand-in plus a
// transaction-level round-robin/sum reference model.
module tb_serial_adder_scheduler;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned LAT = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   grant;
  logic           busy;
  logic           done;
  logic [W-1:0]   sum;
  logic           cout;
  logic           add_rst;
  logic           add_mode;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_ans;
  logic           add_carry;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [N-1:0] req_v;
  int unsigned  ptr_m;

  serial_adder_scheduler #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .grant(grant), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .add_rst(add_rst), .add_mode(add_mode), .add_a(add_a), .add_b(add_b),
    .add_ans(add_ans), .add_carry(add_carry)
  );

  always #5 clk = ~clk;

  // Adder stand-in: result only becomes correct LAT-1 run cycles after the
  // load pulse; before that it presents a corrupted value.
  logic [7:0] k_q;
  logic [W:0] true_sum;
  always @(posedge clk) begin
    if (add_rst) k_q <= '0;
    else if (add_mode && k_q != 8'hFF) k_q <= k_q + 8'd1;
  end
  assign true_sum = {1'b0, add_a} + {1'b0, add_b};
  assign {add_carry, add_ans} = (k_q >= 8'(LAT - 1)) ? true_sum : ~true_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned p);
    for (int unsigned k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return N;
  endfunction

  task automatic set_ops(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic run_op(input bit perturb);
    int unsigned  w;
    logic [W-1:0] ea, eb;
    logic [W:0]   es;
    logic [N-1:0] oh;
    w  = rr_pick(req_v, ptr_m);
    oh = '0;
    oh[w] = 1'b1;
    ea = a_in[w*W +: W];
    eb = b_in[w*W +: W];
    es = {1'b0, ea} + {1'b0, eb};
    step();
    check("grant", 32'(grant), 32'(oh));
    check("load_rst", 32'(add_rst), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    for (int unsigned n = 0; n < LAT; n++) begin
      step();
      check("run_nodone", 32'(done), 32'd0);
      if (perturb && n == 3) begin
        for (int unsigned i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
        req_v[w] = 1'b0;
        req = req_v;
      end
    end
    step();
    check("done", 32'(done), 32'd1);
    check("done_grant", 32'(grant), 32'(oh));
    check("sum", 32'(sum), 32'(es[W-1:0]));
    check("cout", 32'(cout), 32'(es[W]));
    check("add_a_held", 32'(add_a), 32'(ea));
    req_v[w] = 1'b0;
    req = req_v;
    ptr_m = (w + 1) % N;
    step();
    check("post_done", 32'(done), 32'd0);
    check("post_grant", 32'(grant), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("sum_held", 32'(sum), 32'(es[W-1:0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] nw;
    rst = 1'b1; req = '0; req_v = '0; a_in = '0; b_in = '0; ptr_m = 0;
    step(); step(); step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_rst", 32'(add_rst), 32'd1);
    check("rst_add_mode", 32'(add_mode), 32'd0);
    rst = 1'b0;
    step();

    set_ops(0, 8'h33, 8'h92); req_v = 4'b0001; req = req_v; run_op(1'b0);
    set_ops(2, 8'hFF, 8'h01); req_v = 4'b0100; req = req_v; run_op(1'b0);

    // Reset in the middle of RUN (cnt==3)
    set_ops(1, 8'h5A, 8'h3C); req_v = 4'b0010; req = req_v;
    step();
    check("rst_test_grant", 32'(grant), 32'b0010);
    for (int unsigned n = 0; n < 4; n++) step();
    rst = 1'b1;
    step();
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    rst = 1'b0; req_v = '0; req = '0; ptr_m = 0;
    for (int unsigned n = 0; n < LAT + 4; n++) begin
      step();
      check("abort_nodone", 32'(done), 32'd0);
    end

    for (int unsigned i = 0; i < N; i++) set_ops(i, W'(8'h11 * (i + 1)), W'(8'hE0 + i));
    for (int unsigned g = 0; g < 5; g++) begin
      req_v = '1; req = req_v; run_op(1'b0);
    end

    req_v = 4'b0011; req = req_v; run_op(1'b0);
    req_v = 4'b0011; req = req_v; run_op(1'b0);
    run_op(1'b0);

    set_ops(1, 8'h80, 8'h81); req_v = 4'b0010; req = req_v; run_op(1'b1);

    for (int unsigned t = 0; t < 24; t++) begin
      nw = N'($urandom_range(0, (1 << N) - 1)) & ~req_v;
      for (int unsigned i = 0; i < N; i++)
        if (nw[i]) set_ops(i, W'($urandom), W'($urandom));
      req_v = req_v | nw;
      if (req_v == '0) begin
        nw = '0;
        nw[$urandom_range(0, N - 1)] = 1'b1;
        for (int unsigned i = 0; i < N; i++)
          if (nw[i]) set_ops(i, W'($urandom), W'($urandom));
        req_v = nw;
      end
      req = req_v;
      run_op(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
